// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the multiply/divide unit:
//   - MD op encodings (MD_NONE .. MD_MADD) as seen on the op port
//   - FSM state encoding for md_unit
//   - default busy-period lengths
//   - HI/LO pair type
// -----------------------------------------------------------------------------
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_MADD  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

endpackage

// File: rtl/md_unit_if.sv
// -----------------------------------------------------------------------------
// md_unit_if
//   E-stage request / HI-LO result bundle of the multiply/divide unit.
//   start, op, D1, D2 : request from the pipeline (master drives)
//   busy, hi, lo      : unit status and architectural HI/LO (slave drives)
// -----------------------------------------------------------------------------
interface md_unit_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] D1;
    logic [31:0] D2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, D1, D2, input busy, hi, lo);
    modport slave  (input start, op, D1, D2, output busy, hi, lo);

endinterface

// File: rtl/md_div_core.sv
// -----------------------------------------------------------------------------
// md_div_core
//   Combinational 32-bit divider, signed or unsigned.
//   Quotient truncates toward zero, remainder takes the dividend's sign.
//   Ports:
//     i_a      dividend
//     i_b      divisor
//     i_signed 1 = two's-complement operands
//     o_q      quotient (0 when dividing by zero)
//     o_r      remainder (0 when dividing by zero)
//     o_dz     divisor is zero; caller must not commit the result
// -----------------------------------------------------------------------------
module md_div_core (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_signed,
    output logic [31:0] o_q,
    output logic [31:0] o_r,
    output logic        o_dz
);

    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;

    assign w_neg_a = i_signed & i_a[31];
    assign w_neg_b = i_signed & i_b[31];
    assign w_mag_a = w_neg_a ? -i_a : i_a;
    assign w_mag_b = w_neg_b ? -i_b : i_b;
    assign o_dz    = (i_b == 32'd0);

    assign w_mag_q = o_dz ? 32'd0 : (w_mag_a / w_mag_b);
    assign w_mag_r = o_dz ? 32'd0 : (w_mag_a % w_mag_b);

    // 0x80000000 / -1 needs no special path: |a| = 0x80000000 as an unsigned
    // magnitude, both signs are negative so the quotient stays 0x80000000
    // and the remainder is 0.
    assign o_q = (w_neg_a ^ w_neg_b) ? -w_mag_q : w_mag_q;
    assign o_r = w_neg_a ? -w_mag_r : w_mag_r;

endmodule

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   The result is computed from the operands at the start edge and held
//   until the commit edge, where HI and LO update together and busy drops.
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     bus    md_unit_if.slave: start/op/D1/D2 in, busy/hi/lo out
//   Parameters:
//     MULT_CYCLES  busy period for MULT/MULTU/MADD
//     DIV_CYCLES   busy period for DIV/DIVU
//   Build option:
//     MD_UNIT_MADD_EN  enables op 7 (MADD: {hi,lo} += signed D1*D2);
//                      without it op 7 does nothing.
// -----------------------------------------------------------------------------
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    md_res_t       r_hl;
    logic [63:0]   r_res;
    logic          r_wr;

    logic [63:0]   w_a_s;
    logic [63:0]   w_b_s;
    logic [63:0]   w_prod_s;
    logic [63:0]   w_prod_u;
    logic [31:0]   w_q;
    logic [31:0]   w_r;
    logic          w_dz;
    logic          w_go_mul;
    logic          w_go_div;
    logic [63:0]   w_res;
    logic          w_last;

    // Low 64 bits of the product of sign-extended operands is the signed product.
    assign w_a_s    = {{32{bus.D1[31]}}, bus.D1};
    assign w_b_s    = {{32{bus.D2[31]}}, bus.D2};
    assign w_prod_s = w_a_s * w_b_s;
    assign w_prod_u = {32'd0, bus.D1} * {32'd0, bus.D2};

    md_div_core u_div (
        .i_a      (bus.D1),
        .i_b      (bus.D2),
        .i_signed (bus.op == MD_DIV),
        .o_q      (w_q),
        .o_r      (w_r),
        .o_dz     (w_dz)
    );

    always_comb begin
        w_go_mul = 1'b0;
        w_go_div = 1'b0;
        w_res    = w_prod_s;
        case (bus.op)
            MD_MULT:  w_go_mul = 1'b1;
            MD_MULTU: begin
                w_go_mul = 1'b1;
                w_res    = w_prod_u;
            end
            MD_DIV, MD_DIVU: begin
                w_go_div = 1'b1;
                w_res    = {w_r, w_q};
            end
`ifdef MD_UNIT_MADD_EN
            // accumulates onto HI/LO as they stand at the start edge
            MD_MADD: begin
                w_go_mul = 1'b1;
                w_res    = r_hl + w_prod_s;
            end
`endif
            default: ;
        endcase
    end

    assign w_last = (r_state == ST_MUL) ? (r_cnt == MUL_LAST) : (r_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hl    <= '0;
            r_res   <= '0;
            r_wr    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (bus.start) begin
                if (w_go_mul || w_go_div) begin
                    r_state <= w_go_mul ? ST_MUL : ST_DIV;
                    r_cnt   <= CW'(1);
                    r_busy  <= 1'b1;
                    r_res   <= w_res;
                    // divide by zero still runs the full period but leaves HI/LO alone
                    r_wr    <= !(w_go_div && w_dz);
                end else if (bus.op == MD_MTHI) begin
                    r_hl.hi <= bus.D1;
                end else if (bus.op == MD_MTLO) begin
                    r_hl.lo <= bus.D1;
                end
            end
        end else if (w_last) begin
            // commit edge: start is ignored here since busy was still high
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            if (r_wr) r_hl <= r_res;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hl.hi;
    assign bus.lo   = r_hl.lo;

endmodule
